// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared fetch definitions: state encoding, halt word, word size
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_HALT_INSTR = 32'h0010_0073;
  localparam int unsigned WORD_BYTES         = 4;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_addr_check.sv
// rtl/fetch_addr_check.sv - flags misaligned or out-of-range word addresses
module fetch_addr_check
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 256
) (
  input  logic [31:0] pc,
  output logic        bad
);

  // 33-bit limit so MEM_SIZE up to 2^30 words cannot wrap the comparison
  localparam logic [32:0] LIMIT = 33'(MEM_SIZE) * 33'(WORD_BYTES);

  always_comb begin
    bad = (pc[1:0] != 2'b00) || ({1'b0, pc} >= LIMIT);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC sequencing, stall/redirect/halt and fetch fault trapping
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned MEM_SIZE   = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = DEFAULT_HALT_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] retired
);

  fetch_state_t state;
  logic [31:0]  pc_q;
  logic         bad;
  logic         is_halt;

  fetch_addr_check #(.MEM_SIZE(MEM_SIZE)) u_addr_check (
    .pc  (pc_q),
    .bad (bad)
  );

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = imem_data;
  assign is_halt     = (imem_data == HALT_INSTR);
  // A bad PC never reaches decode, even if the stale memory word looks legal
  assign instr_valid = (state == ST_RUN) && !bad && !stall;
  assign halted      = (state == ST_HALT);
  assign fault       = (state == ST_FAULT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pc_q       <= RESET_PC;
      fault_addr <= 32'd0;
      retired    <= 32'd0;
    end else begin
      if (instr_valid) begin
        retired <= sat_inc(retired);
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            pc_q  <= RESET_PC;
          end
        end
        ST_RUN: begin
          if (bad) begin
            state      <= ST_FAULT;
            fault_addr <= pc_q;
          end else if (!stall) begin
            if (is_halt) begin
              state <= ST_HALT;
            end else if (redirect_valid) begin
              pc_q <= redirect_pc;
            end else begin
              pc_q <= pc_q + 32'd4;
            end
          end
        end
        ST_HALT, ST_FAULT: begin
          if (start) begin
            state      <= ST_RUN;
            pc_q       <= RESET_PC;
            retired    <= 32'd0;
            fault_addr <= 32'd0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed and randomized checks of fetch_ctrl against a spec-level model
module tb_fetch_ctrl;

  localparam logic [31:0] HALT = 32'h0010_0073;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        rst_n, start, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_data, instr, pc, fault_addr, retired;
  logic        instr_valid, halted, fault;
  logic [31:0] mem [0:255];

  assign imem_data = mem[imem_addr[9:2]];

  fetch_ctrl #(.MEM_SIZE(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_data(imem_data), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .halted(halted), .fault(fault),
    .fault_addr(fault_addr), .retired(retired)
  );

  logic        s_rst_n, s_start;
  logic [31:0] s_imem_addr, s_imem_data, s_instr, s_pc, s_fault_addr, s_retired;
  logic        s_instr_valid, s_halted, s_fault;
  logic [31:0] mem_s [0:3];

  assign s_imem_data = mem_s[s_imem_addr[3:2]];

  fetch_ctrl #(.MEM_SIZE(4)) dut_small (
    .clk(clk), .rst_n(s_rst_n), .start(s_start), .stall(1'b0),
    .redirect_valid(1'b0), .redirect_pc(32'd0),
    .imem_addr(s_imem_addr), .imem_data(s_imem_data), .instr(s_instr),
    .instr_valid(s_instr_valid), .pc(s_pc), .halted(s_halted), .fault(s_fault),
    .fault_addr(s_fault_addr), .retired(s_retired)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 256; i++) mem[i] = NOP + 32'(i << 7);
  endtask

  task automatic do_start();
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    tick();
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    s_rst_n = 1'b0; s_start = 1'b0;
    fill_nop();
    for (int i = 0; i < 4; i++) mem_s[i] = NOP + 32'(i);
    #12;
    checks++; if (pc !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'd0); end
    checks++; if (imem_addr !== 32'd0) begin failures++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, 32'd0); end
    checks++; if ({instr_valid, halted, fault} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {instr_valid, halted, fault}); end
    checks++; if (fault_addr !== 32'd0) begin failures++; $display("FAIL reset_fault_addr got=%h exp=0", fault_addr); end
    checks++; if (retired !== 32'd0) begin failures++; $display("FAIL reset_retired got=%0d exp=0", retired); end
    tick();
    rst_n = 1'b1; s_rst_n = 1'b1;
    tick(); tick();
    checks++; if (instr_valid !== 1'b0 || pc !== 32'd0) begin failures++; $display("FAIL idle_hold valid=%b pc=%h exp valid=0 pc=0", instr_valid, pc); end
  endtask

  task automatic test_straight();
    do_start();
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem_addr !== 32'(4 * i)) begin failures++; $display("FAIL straight_addr[%0d] got=%h exp=%h", i, imem_addr, 32'(4 * i)); end
      checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL straight_valid[%0d] got=%b exp=1", i, instr_valid); end
      checks++; if (instr !== mem[i]) begin failures++; $display("FAIL straight_instr[%0d] got=%h exp=%h", i, instr, mem[i]); end
      tick();
    end
    checks++; if (retired !== 32'd4) begin failures++; $display("FAIL straight_retired got=%0d exp=4", retired); end
  endtask

  task automatic test_stall();
    do_start();
    tick(); tick();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (pc !== 32'h8 || instr_valid !== 1'b0) begin failures++; $display("FAIL stall_hold[%0d] pc=%h valid=%b exp pc=8 valid=0", i, pc, instr_valid); end
      checks++; if (retired !== 32'd2) begin failures++; $display("FAIL stall_retired[%0d] got=%0d exp=2", i, retired); end
      tick();
    end
    stall = 1'b0;
    #1;
    checks++; if (pc !== 32'h8 || instr_valid !== 1'b1) begin failures++; $display("FAIL stall_release pc=%h valid=%b exp pc=8 valid=1", pc, instr_valid); end
    tick();
    checks++; if (pc !== 32'hC) begin failures++; $display("FAIL stall_next got=%h exp=c", pc); end
  endtask

  task automatic test_redirect();
    do_start();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1;
    checks++; if (pc !== 32'h4 || instr_valid !== 1'b1) begin failures++; $display("FAIL redir_src pc=%h valid=%b exp pc=4 valid=1", pc, instr_valid); end
    tick();
    checks++; if (imem_addr !== 32'h40) begin failures++; $display("FAIL redir_target got=%h exp=40", imem_addr); end
    redirect_pc = 32'h42;
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++; if (pc !== 32'h42 || instr_valid !== 1'b0 || fault !== 1'b0) begin failures++; $display("FAIL redir_bad pc=%h valid=%b fault=%b exp 42/0/0", pc, instr_valid, fault); end
    tick();
    checks++; if (fault !== 1'b1 || fault_addr !== 32'h42) begin failures++; $display("FAIL redir_fault fault=%b addr=%h exp 1/42", fault, fault_addr); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL redir_fault_valid got=%b exp=0", instr_valid); end
  endtask

  task automatic test_halt();
    mem[3] = HALT;
    do_start();
    tick(); tick(); tick();
    checks++; if (pc !== 32'hC || instr_valid !== 1'b1 || halted !== 1'b0) begin failures++; $display("FAIL halt_word pc=%h valid=%b halted=%b exp c/1/0", pc, instr_valid, halted); end
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    checks++; if (halted !== 1'b1 || pc !== 32'hC || instr_valid !== 1'b0) begin failures++; $display("FAIL halt_state halted=%b pc=%h valid=%b exp 1/c/0", halted, pc, instr_valid); end
    checks++; if (retired !== 32'd4) begin failures++; $display("FAIL halt_retired got=%0d exp=4", retired); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (pc !== 32'd0 || retired !== 32'd0 || halted !== 1'b0) begin failures++; $display("FAIL halt_restart pc=%h retired=%0d halted=%b exp 0/0/0", pc, retired, halted); end
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL halt_restart_valid got=%b exp=1", instr_valid); end
    mem[3] = NOP;
  endtask

  task automatic test_small_range();
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (s_pc !== 32'(4 * i) || s_instr_valid !== 1'b1) begin failures++; $display("FAIL small_run[%0d] pc=%h valid=%b exp %h/1", i, s_pc, s_instr_valid, 32'(4 * i)); end
      tick();
    end
    checks++; if (s_pc !== 32'h10 || s_instr_valid !== 1'b0) begin failures++; $display("FAIL small_edge pc=%h valid=%b exp 10/0", s_pc, s_instr_valid); end
    tick();
    checks++; if (s_fault !== 1'b1 || s_fault_addr !== 32'h10 || s_retired !== 32'd4) begin failures++; $display("FAIL small_fault fault=%b addr=%h retired=%0d exp 1/10/4", s_fault, s_fault_addr, s_retired); end
  endtask

  task automatic test_async_reset();
    do_start();
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (pc !== 32'd0 || retired !== 32'd0 || instr_valid !== 1'b0) begin failures++; $display("FAIL areset_now pc=%h retired=%0d valid=%b exp 0/0/0", pc, retired, instr_valid); end
    checks++; if (halted !== 1'b0 || fault !== 1'b0 || fault_addr !== 32'd0) begin failures++; $display("FAIL areset_flags halted=%b fault=%b addr=%h exp 0/0/0", halted, fault, fault_addr); end
    tick();
    #2;
    rst_n = 1'b1;
    tick(); tick();
    checks++; if (pc !== 32'd0 || instr_valid !== 1'b0) begin failures++; $display("FAIL areset_idle pc=%h valid=%b exp 0/0", pc, instr_valid); end
  endtask

  task automatic test_random();
    logic [31:0] m_pc, m_ret, m_faddr, word;
    bit          m_run, m_halt, m_fault, m_bad, exp_valid;
    for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 15) == 0) ? HALT : ($urandom | 32'h1);
    do_start();
    m_pc = 32'd0; m_ret = 32'd0; m_faddr = 32'd0;
    m_run = 1'b1; m_halt = 1'b0; m_fault = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      stall          = ($urandom_range(0, 4) == 0);
      redirect_valid = ($urandom_range(0, 3) == 0);
      redirect_pc    = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255) * 4);
      start          = ($urandom_range(0, 7) == 0);
      #1;
      m_bad     = (m_pc % 4 != 0) || (64'(m_pc) >= 64'd1024);
      exp_valid = m_run && !m_bad && !stall;
      word      = m_bad ? 32'd0 : mem[m_pc / 4];
      checks++; if (pc !== m_pc || imem_addr !== m_pc) begin failures++; $display("FAIL rand_pc[%0d] pc=%h addr=%h exp=%h", cyc, pc, imem_addr, m_pc); end
      checks++; if (instr_valid !== exp_valid) begin failures++; $display("FAIL rand_valid[%0d] got=%b exp=%b", cyc, instr_valid, exp_valid); end
      checks++; if (halted !== m_halt || fault !== m_fault) begin failures++; $display("FAIL rand_flags[%0d] halted=%b fault=%b exp %b/%b", cyc, halted, fault, m_halt, m_fault); end
      checks++; if (fault_addr !== m_faddr || retired !== m_ret) begin failures++; $display("FAIL rand_regs[%0d] faddr=%h retired=%0d exp %h/%0d", cyc, fault_addr, retired, m_faddr, m_ret); end
      if (exp_valid) begin
        checks++; if (instr !== word) begin failures++; $display("FAIL rand_instr[%0d] got=%h exp=%h", cyc, instr, word); end
      end
      if (m_run) begin
        if (m_bad) begin
          m_run = 1'b0; m_fault = 1'b1; m_faddr = m_pc;
        end else if (!stall) begin
          if (m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 1;
          if (word == HALT) begin
            m_run = 1'b0; m_halt = 1'b1;
          end else begin
            m_pc = redirect_valid ? redirect_pc : m_pc + 32'd4;
          end
        end
      end else if (start) begin
        m_run = 1'b1; m_halt = 1'b0; m_fault = 1'b0;
        m_pc = 32'd0; m_ret = 32'd0; m_faddr = 32'd0;
      end
      tick();
    end
    start = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_straight();
    test_stall();
    test_redirect();
    test_halt();
    test_small_range();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
